elevator_dispatcher: RTL

Hall-call scheduler that sits in front of a two-car elevator datapath.
- Queues floor requests in arrival order and suppresses duplicates.
- Supports cancellation of queued requests.
- Hands the oldest request to an idle car through a valid/ack handshake, one car assignment at a time.

---
 rtl/elevator_dispatcher.sv | 123 ++++++++++++
 1 files changed

// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: hall-call queue feeding two cars through a valid/ack offer.
// Ports: CLK/RST (sync, active-high); req_valid/req_floor -> req_accept;
// cancel_valid/cancel_floor -> cancel_done; carN_idle/carN_floor car status;
// assignN_valid/assignN_floor/assignN_ack offer handshake; count/full queue status.
// Build option NEAREST_CAR_EN: with both cars idle, offer to the nearer car (tie -> car 1).
module elevator_dispatcher #(
    parameter int FLOORS = 8,
    parameter int DEPTH  = 8,
    parameter int FW     = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    input  logic [FW-1:0] req_floor,
    output logic          req_accept,
    input  logic          cancel_valid,
    input  logic [FW-1:0] cancel_floor,
    output logic          cancel_done,
    input  logic          car1_idle,
    input  logic          car2_idle,
    input  logic [FW-1:0] car1_floor,
    input  logic [FW-1:0] car2_floor,
    output logic          assign1_valid,
    output logic [FW-1:0] assign1_floor,
    input  logic          assign1_ack,
    output logic          assign2_valid,
    output logic [FW-1:0] assign2_floor,
    input  logic          assign2_ack,
    output logic [FW-1:0] count,
    output logic          full
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [FW-1:0] queue_q [DEPTH];
    logic [FW-1:0] queue_d [DEPTH];
    logic [FW-1:0] count_q, count_d, floor_q, floor_d, cidx;
    logic [0:0]    state_q, state_d;
    logic          sel_q, sel_d, req_accept_q, req_accept_d, cancel_done_q, cancel_done_d;
    logic          pop, start, can_hit, dup, in_range, enq, sel_pick;

`ifdef NEAREST_CAR_EN
    logic [FW:0] dist1, dist2;
    always_comb begin
        dist1 = (car1_floor > queue_q[0]) ? {1'b0, car1_floor} - {1'b0, queue_q[0]}
                                          : {1'b0, queue_q[0]} - {1'b0, car1_floor};
        dist2 = (car2_floor > queue_q[0]) ? {1'b0, car2_floor} - {1'b0, queue_q[0]}
                                          : {1'b0, queue_q[0]} - {1'b0, car2_floor};
        sel_pick = (car1_idle && car2_idle) ? (dist2 < dist1) : !car1_idle;
    end
`else
    assign sel_pick = !car1_idle;
`endif

    always_comb begin
        pop   = (state_q == S_OFFER) && (sel_q ? assign2_ack : assign1_ack);
        start = (state_q == S_IDLE) && (count_q != '0) && (car1_idle || car2_idle);
        queue_d = queue_q;
        count_d = count_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) queue_d[i] = queue_q[i + 1];
            queue_d[DEPTH-1] = '0;
            count_d = count_q - 1'b1;
        end
        can_hit = 1'b0;
        cidx    = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cancel_valid && !can_hit && FW'(i) < count_d && queue_d[i] == cancel_floor) begin
                can_hit = 1'b1;
                cidx    = FW'(i);
            end
        // The head is pinned while it is being offered or latched for an offer this edge.
        if (cidx == '0 && ((state_q == S_OFFER && !pop) || start)) can_hit = 1'b0;
        if (can_hit) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (FW'(i) >= cidx) queue_d[i] = queue_d[i + 1];
            queue_d[DEPTH-1] = '0;
            count_d = count_d - 1'b1;
        end
        in_range = (req_floor != '0) && (req_floor <= FW'(FLOORS));
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (FW'(i) < count_d && queue_d[i] == req_floor) dup = 1'b1;
        enq = req_valid && in_range && !dup && (count_d < FW'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            if (enq && FW'(i) == count_d) queue_d[i] = req_floor;
        count_d       = enq ? count_d + 1'b1 : count_d;
        req_accept_d  = req_valid && in_range && (dup || enq);
        cancel_done_d = can_hit;
        state_d = start ? S_OFFER : (pop ? S_IDLE : state_q);
        floor_d = start ? queue_q[0] : floor_q;
        sel_d   = start ? sel_pick : sel_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
            count_q       <= '0;
            floor_q       <= '0;
            state_q       <= S_IDLE;
            sel_q         <= 1'b0;
            req_accept_q  <= 1'b0;
            cancel_done_q <= 1'b0;
        end else begin
            queue_q       <= queue_d;
            count_q       <= count_d;
            floor_q       <= floor_d;
            state_q       <= state_d;
            sel_q         <= sel_d;
            req_accept_q  <= req_accept_d;
            cancel_done_q <= cancel_done_d;
        end
    end

    assign assign1_valid = (state_q == S_OFFER) && !sel_q;
    assign assign2_valid = (state_q == S_OFFER) && sel_q;
    assign assign1_floor = assign1_valid ? floor_q : '0;
    assign assign2_floor = assign2_valid ? floor_q : '0;
    assign req_accept    = req_accept_q;
    assign cancel_done   = cancel_done_q;
    assign count         = count_q;
    assign full          = (count_q == FW'(DEPTH));
endmodule
